// File: rtl/mem_access_pkg.sv
// Shared encodings for the load/store front-end: access sizes, FSM states and lane widths.
package mem_access_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  localparam int LANE_BYTE_W = 8;
  localparam int LANE_HALF_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RD,
    ST_WR,
    ST_RESP
  } state_t;

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] offset);
    return (size == SZ_RSVD) ||
           ((size == SZ_HALF) && offset[0]) ||
           ((size == SZ_WORD) && (offset != 2'b00));
  endfunction

endpackage

// File: rtl/mem_lane_merge.sv
// Combinational lane logic: replaces the addressed byte/half lane for stores and
// extracts plus sign/zero-extends the addressed lane for loads.
module mem_lane_merge
  import mem_access_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        is_signed,
  input  logic [1:0]  offset,
  input  logic [31:0] word,
  input  logic [15:0] wdata,
  output logic [31:0] merged,
  output logic [31:0] extracted
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  assign byte_lane = word[{offset, 3'b000} +: LANE_BYTE_W];
  assign half_lane = word[{offset[1], 4'b0000} +: LANE_HALF_W];

  always_comb begin
    merged    = word;
    extracted = word;
    case (size)
      SZ_BYTE: begin
        merged[{offset, 3'b000} +: LANE_BYTE_W] = wdata[7:0];
        extracted = {{24{is_signed & byte_lane[7]}}, byte_lane};
      end
      SZ_HALF: begin
        merged[{offset[1], 4'b0000} +: LANE_HALF_W] = wdata;
        extracted = {{16{is_signed & half_lane[15]}}, half_lane};
      end
      default: begin
        merged    = word;
        extracted = word;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store front-end between the MEM stage and a word-addressed data memory.
// Optional macro MEM_ACCESS_PERF_EN adds load/store/fault completion counters.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int DEPTH_WORDS = 1025
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_fault,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  input  logic [31:0] mem_rdata
`ifdef MEM_ACCESS_PERF_EN
  ,
  output logic [31:0] perf_loads,
  output logic [31:0] perf_stores,
  output logic [31:0] perf_faults
`endif
);

  state_t      state;
  logic        store_q;
  logic        signed_q;
  logic [1:0]  size_q;
  logic [1:0]  offset_q;
  logic [15:0] wdata_q;
  logic        req_fault;
  logic [31:0] merged;
  logic [31:0] extracted;

  assign req_ready = (state == ST_IDLE);
  assign req_fault = misaligned(req_size, req_addr[1:0]) ||
                     ({2'b00, req_addr[31:2]} >= 32'(DEPTH_WORDS));

  mem_lane_merge u_lane (
    .size      (size_q),
    .is_signed (signed_q),
    .offset    (offset_q),
    .word      (mem_rdata),
    .wdata     (wdata_q),
    .merged    (merged),
    .extracted (extracted)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      store_q    <= 1'b0;
      signed_q   <= 1'b0;
      size_q     <= SZ_BYTE;
      offset_q   <= 2'b00;
      wdata_q    <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_fault <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_we     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            store_q  <= req_store;
            signed_q <= req_signed;
            size_q   <= req_size;
            offset_q <= req_addr[1:0];
            wdata_q  <= req_wdata[15:0];
            mem_addr <= {2'b00, req_addr[31:2]};
            if (req_fault) begin
              resp_valid <= 1'b1;
              resp_fault <= 1'b1;
              resp_rdata <= '0;
              state      <= ST_RESP;
            end else if (req_store && (req_size == SZ_WORD)) begin
              mem_wdata <= req_wdata;
              mem_we    <= 1'b1;
              state     <= ST_WR;
            end else begin
              state <= ST_RD;
            end
          end
        end
        // Sub-word stores merge the freshly read word; loads complete here.
        ST_RD: begin
          if (store_q) begin
            mem_wdata <= merged;
            mem_we    <= 1'b1;
            state     <= ST_WR;
          end else begin
            resp_valid <= 1'b1;
            resp_rdata <= extracted;
            state      <= ST_RESP;
          end
        end
        ST_WR: begin
          mem_we     <= 1'b0;
          resp_valid <= 1'b1;
          resp_rdata <= '0;
          state      <= ST_RESP;
        end
        ST_RESP: begin
          resp_valid <= 1'b0;
          resp_fault <= 1'b0;
          resp_rdata <= '0;
          mem_addr   <= '0;
          state      <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef MEM_ACCESS_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_loads  <= '0;
      perf_stores <= '0;
      perf_faults <= '0;
    end else if (resp_valid) begin
      if (resp_fault)   perf_faults <= perf_faults + 32'd1;
      else if (store_q) perf_stores <= perf_stores + 32'd1;
      else              perf_loads  <= perf_loads + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a behavioural data memory and a response scoreboard.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_store = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_signed = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_fault;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic [31:0] mem_rdata;
`ifdef MEM_ACCESS_PERF_EN
  logic [31:0] perf_loads, perf_stores, perf_faults;
  int          n_ld = 0, n_st = 0, n_ft = 0;
`endif

  always #5 clk = ~clk;

  logic [31:0] tb_mem  [0:2047];
  logic [31:0] ref_mem [0:2047];

  assign mem_rdata = tb_mem[mem_addr[10:0]];
  always @(posedge clk) if (mem_we) tb_mem[mem_addr[10:0]] <= mem_wdata;

  typedef struct packed {
    logic        fault;
    logic [31:0] rdata;
  } resp_t;
  resp_t exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  mem_access_unit #(.DEPTH_WORDS(1025)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_store  (req_store),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_fault (resp_fault),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .mem_rdata  (mem_rdata)
`ifdef MEM_ACCESS_PERF_EN
    ,
    .perf_loads  (perf_loads),
    .perf_stores (perf_stores),
    .perf_faults (perf_faults)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One request: model the expected outcome, drive it, then track writes and the response.
  task automatic txn(input logic st, input logic [1:0] sz, input logic sg,
                     input logic [31:0] a, input logic [31:0] wd,
                     input int exp_lat, input string tag);
    logic        flt;
    logic [31:0] idx, w, v, mask, exp_word;
    int          sh, writes, lat;
    resp_t       r;
    idx = a >> 2;
    flt = (sz == 2'b11) || (sz == 2'b01 && a[0]) ||
          (sz == 2'b10 && a[1:0] != 2'b00) || (idx >= 32'd1025);
    v = '0;
    exp_word = '0;
    if (!flt) begin
      w    = ref_mem[idx[10:0]];
      sh   = 8 * int'(a[1:0]);
      mask = (sz == 2'b00) ? 32'h0000_00FF : (sz == 2'b01) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
      if (st) begin
        exp_word = (w & ~(mask << sh)) | ((wd & mask) << sh);
        ref_mem[idx[10:0]] = exp_word;
      end else begin
        v = (w >> sh) & mask;
        if (sg && sz == 2'b00 && v[7])  v = v | 32'hFFFF_FF00;
        if (sg && sz == 2'b01 && v[15]) v = v | 32'hFFFF_0000;
      end
    end
`ifdef MEM_ACCESS_PERF_EN
    if (flt) n_ft++; else if (st) n_st++; else n_ld++;
`endif
    exp_q.push_back({flt, v});

    @(negedge clk);
    req_valid  = 1'b1;
    req_store  = st;
    req_size   = sz;
    req_signed = sg;
    req_addr   = a;
    req_wdata  = wd;
    check({tag, ":ready_before"}, 32'(req_ready), 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;

    writes = 0;
    lat    = -1;
    for (int c = 1; c <= 8 && lat < 0; c++) begin
      @(negedge clk);
      if (!flt && c == 1) check({tag, ":mem_addr"}, mem_addr, idx);
      if (mem_we) begin
        writes++;
        check({tag, ":we_cycle"}, 32'(c), 32'(exp_lat - 1));
        check({tag, ":we_addr"}, mem_addr, idx);
        check({tag, ":we_data"}, mem_wdata, exp_word);
      end
      if (resp_valid) begin
        lat = c;
        if (exp_q.size() == 0) begin
          check({tag, ":unexpected_resp"}, 32'd1, 32'd0);
        end else begin
          r = exp_q.pop_front();
          check({tag, ":fault"}, 32'(resp_fault), 32'(r.fault));
          check({tag, ":rdata"}, resp_rdata, r.rdata);
        end
      end
    end
    check({tag, ":latency"}, 32'(lat), 32'(exp_lat));
    check({tag, ":writes"}, 32'(writes), (st && !flt) ? 32'd1 : 32'd0);
    @(negedge clk);
    check({tag, ":resp_pulse_end"}, 32'(resp_valid), 32'd0);
    check({tag, ":ready_after"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int we_seen, resp_seen;
    for (int i = 0; i < 2048; i++) ref_mem[i] = '0;

    // Reset state, with a request held during reset that must not be taken.
    req_valid = 1'b1;
    req_addr  = 32'h10;
    req_size  = 2'b10;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst:ready",      32'(req_ready),  32'd1);
    check("rst:resp_valid", 32'(resp_valid), 32'd0);
    check("rst:resp_rdata", resp_rdata,      32'd0);
    check("rst:resp_fault", 32'(resp_fault), 32'd0);
    check("rst:mem_we",     32'(mem_we),     32'd0);
    check("rst:mem_wdata",  mem_wdata,       32'd0);
    check("rst:mem_addr",   mem_addr,        32'd0);
    req_valid = 1'b0;
    rst_n     = 1'b1;
    @(negedge clk);

    // Word store then load back.
    txn(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 2, "sw_0x10");
    txn(1'b0, 2'b10, 1'b0, 32'h10, 32'h0,        2, "lw_0x10");
    // Byte store read-modify-write, then restore the word.
    txn(1'b1, 2'b00, 1'b0, 32'h11, 32'h000000A5, 3, "sb_0x11");
    txn(1'b0, 2'b10, 1'b0, 32'h10, 32'h0,        2, "lw_after_sb");
    txn(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 2, "sw_restore");
    // Sub-word load extraction and extension.
    txn(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 2, "lb_0x13");
    txn(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 2, "lbu_0x13");
    txn(1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 2, "lh_0x12");
    txn(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 2, "lhu_0x12");
    txn(1'b0, 2'b00, 1'b1, 32'h10, 32'h0, 2, "lb_0x10");
    txn(1'b0, 2'b10, 1'b1, 32'h10, 32'h0, 2, "lw_signed_ignored");
    // Halfword store into the upper lane.
    txn(1'b1, 2'b01, 1'b0, 32'h12, 32'h1234CAFE, 3, "sh_0x12");
    txn(1'b0, 2'b01, 1'b1, 32'h12, 32'h0,        2, "lh_after_sh");
    txn(1'b0, 2'b10, 1'b0, 32'h10, 32'h0,        2, "lw_after_sh");
    // Alignment and reserved-size faults.
    txn(1'b0, 2'b01, 1'b0, 32'h11, 32'h0,        1, "lh_misaligned");
    txn(1'b0, 2'b10, 1'b0, 32'h12, 32'h0,        1, "lw_misaligned");
    txn(1'b0, 2'b11, 1'b0, 32'h10, 32'h0,        1, "size_reserved");
    txn(1'b1, 2'b10, 1'b0, 32'h13, 32'h55555555, 1, "sw_misaligned");
    // Range boundary at DEPTH_WORDS.
    txn(1'b1, 2'b10, 1'b0, 32'h1000, 32'h12345678, 2, "sw_last_word");
    txn(1'b0, 2'b10, 1'b0, 32'h1000, 32'h0,        2, "lw_last_word");
    txn(1'b0, 2'b10, 1'b0, 32'h1004, 32'h0,        1, "lw_out_of_range");
    txn(1'b1, 2'b01, 1'b0, 32'h1006, 32'hBEEF,     1, "sh_out_of_range");

    // Reset during the read phase of a sub-word store.
    txn(1'b1, 2'b10, 1'b0, 32'h20, 32'h11223344, 2, "sw_0x20");
    @(negedge clk);
    req_valid = 1'b1;
    req_store = 1'b1;
    req_size  = 2'b00;
    req_addr  = 32'h21;
    req_wdata = 32'h000000EE;
    @(posedge clk);
    #1 req_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1 check("rst_mid:we_now", 32'(mem_we), 32'd0);
    we_seen   = 0;
    resp_seen = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (mem_we) we_seen++;
      if (resp_valid) resp_seen++;
      check("rst_mid:ready", 32'(req_ready), 32'd1);
    end
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (mem_we) we_seen++;
      if (resp_valid) resp_seen++;
    end
    check("rst_mid:no_write", 32'(we_seen),   32'd0);
    check("rst_mid:no_resp",  32'(resp_seen), 32'd0);
    check("rst_mid:mem_kept", tb_mem[8],      32'h11223344);
`ifdef MEM_ACCESS_PERF_EN
    n_ld = 0;
    n_st = 0;
    n_ft = 0;
`endif
    txn(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 2, "lw_after_reset");
    txn(1'b0, 2'b00, 1'b0, 32'h21, 32'h0, 2, "lbu_after_reset");
    txn(1'b1, 2'b00, 1'b0, 32'h22, 32'h0000007F, 3, "sb_after_reset");
    txn(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 2, "lw_after_sb_reset");

`ifdef MEM_ACCESS_PERF_EN
    check("perf:loads",  perf_loads,  32'(n_ld));
    check("perf:stores", perf_stores, 32'(n_st));
    check("perf:faults", perf_faults, 32'(n_ft));
`endif
    check("scoreboard:empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
